dsp_adder_arbiter: RTL and testbench
====================================

// Module: dsp_adder_arbiter
// PURPOSE
//  Shares one dsp48a1_adder (48-bit post-adder, P registered, 1-cycle latency) between NREQ
//  requesters, e.g. the L/R sigma-delta DAC sequencers and the mixer/filter engines.
//  Arbitration is round-robin per cycle; a requester may lock the adder for a multi-cycle burst
//  so that ZIN_POUT accumulation chains are not interleaved with other requesters.
//  The arbiter returns P to all requesters, with a per-requester valid strobe.
// PARAMETERS
//  NREQ       4    number of requesters (2..8)
//  MAX_BURST  16   max cycles one lock may own the adder before forced release (>=2)
// PORTS
//  clk        in   1        clock
//  reset      in   1        asynchronous, active-high
//  req        in   NREQ     req[i]: operands of requester i are valid this cycle
//  lock       in   NREQ     lock[i]: keep ownership after this op (burst continues)
//  opmode_in  in   8*NREQ   packed per-requester DSP opmode, slice i = [8*i+7:8*i]
//  dab_in     in   48*NREQ  packed per-requester D:A:B operand
//  c_in       in   48*NREQ  packed per-requester C operand
//  gnt        out  NREQ     one-hot/zero; op of requester i is issued to the adder this cycle
//  p_vld      out  NREQ     p_vld[i]=1: p_out is the result of i's op issued in the previous cycle
//  p_out      out  48       adder P, broadcast
//  lock_err   out  1        sticky; set on a forced release, cleared only by reset
//  opmode     out  8        to adder
//  dab        out  48       to adder
//  c          out  48       to adder
//  p_in       in   48       from adder
// BEHAVIOUR
//  - Reset values:
//    - gnt = 0, p_vld = 0, lock_err = 0, owner_vld = 0, rr_ptr = 0, burst_cnt = 0.
//    - Adder bus = `DSP_NOP / 0 / 0.
//  - gnt is combinational from req and registered state. The adder mux follows gnt in the same
//    cycle. A requester holds its operands while req=1 and the op completes in a gnt=1 cycle.
//  - States: IDLE (owner_vld=0) and OWNED (owner_vld=1, owner index registered).
//  - IDLE: gnt = first set req bit at or after rr_ptr, wrapping modulo NREQ. No req -> gnt=0.
//    - Granted i with lock[i]=1 -> OWNED(owner=i), burst_cnt=1.
//    - Granted i with lock[i]=0 -> stay IDLE, rr_ptr=(i+1)%NREQ.
//  - OWNED: only the owner may be granted; gnt[owner]=req[owner], all other gnt=0.
//    - burst_cnt increments every OWNED cycle, granted or not.
//    - Owner granted with lock=0 -> IDLE, rr_ptr=(owner+1)%NREQ.
//    - lock without req has no effect on the transition.
//  - Forced release: the OWNED cycle in which burst_cnt==MAX_BURST-1.
//    - This cycle's grant (if any) is still issued.
//    - Next state is IDLE, rr_ptr=(owner+1)%NREQ, lock_err<=1.
//  - Idle cycle (gnt=0): opmode=`DSP_NOP, dab=0, c=0. P across idle cycles is undefined,
//    so burst sequencers must keep req asserted.
//  - p_vld <= gnt, registered. p_out=p_in, combinational. Result latency = 1 cycle after gnt.
//  - lock[i] is sampled only in cycles where gnt[i]=1.
//  - Simultaneous events:
//    - release + new requests: the next grant uses the updated rr_ptr in the following cycle.
//    - forced release and normal release in the same cycle: handled as a normal release,
//      but lock_err is still set.
//  - Reset mid-burst: ownership dropped, adder bus to NOP at once, pending p_vld discarded.
// STRUCTURE
//  - globals.vh holds the DSP_* opmode macros (used as is) plus new `ARB_MAX_NREQ (8).
//  - One sub-module: rr_pick #(N) (req, ptr -> one-hot pick, combinational, wrap search).
//  - Top contains the owner/rr_ptr/burst_cnt registers, the operand mux and the p_vld register.
// TESTING
//  - Reset, no req: gnt=0, opmode=`DSP_NOP, p_vld=0 for 10 cycles.
//  - req=4'b1111, lock=0 for 8 cycles: gnt = 0001,0010,0100,1000,0001,... and
//    p_vld equals gnt delayed by 1.
//  - req0 locked burst of 4 ops (last lock=0) while req2=1 throughout:
//    - gnt0 x4, then gnt2.
//    - dab=48'h20000 ADD POUT chain yields p_out 0x20000,0x40000,0x60000,0x80000.
//  - Owner 1 drops req for 2 cycles mid-lock with req3=1: gnt=0 both cycles, NOP issued,
//    owner 1 resumes.
//  - req0 lock held forever, MAX_BURST=16: grant to 0 lasts 16 cycles, then lock_err=1 and
//    the next grant goes to req1 if set.
//  - Assert reset during OWNED state with gnt=1: gnt and p_vld go 0 immediately; after release
//    the first grant goes to index 0.

Source files
------------

// File: rtl/dsp_adder_arbiter_pkg.sv
// Shared constants and types for the DSP post-adder arbiter.
// Opmodes follow the DSP48A1 X/Z mux encoding (X = opmode[1:0], Z = opmode[3:2]).
package dsp_adder_arbiter_pkg;

  localparam int ARB_MAX_NREQ = 8;

  localparam logic [7:0] DSP_NOP      = 8'h00;
  localparam logic [7:0] DSP_ADD_C    = 8'h0F;
  localparam logic [7:0] DSP_ADD_POUT = 8'h0B;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dsp_adder_arbiter_if.sv
// Requester-side bundle and adder-side bus of the shared DSP post-adder.
interface dsp_adder_arbiter_if #(parameter int NREQ = 4);

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [8*NREQ-1:0]    opmode_in;
  logic [48*NREQ-1:0]   dab_in;
  logic [48*NREQ-1:0]   c_in;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      p_vld;
  logic [47:0]          p_out;

  modport master (
    output req, lock, opmode_in, dab_in, c_in,
    input  gnt, p_vld, p_out
  );

  modport slave (
    input  req, lock, opmode_in, dab_in, c_in,
    output gnt, p_vld, p_out
  );

endinterface

interface dsp_adder_bus_if;

  logic [7:0]  opmode;
  logic [47:0] dab;
  logic [47:0] c;
  logic [47:0] p_in;

  modport master (
    output opmode, dab, c,
    input  p_in
  );

  modport slave (
    input  opmode, dab, c,
    output p_in
  );

endinterface

// File: rtl/dsp_adder_arbiter_rr_pick.sv
// Round-robin pick: lowest set req bit at or above ptr, otherwise wraps to the
// lowest set bit overall. Output is one-hot, or zero when no request is set.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick
);

  logic [N-1:0] upper;
  logic [N-1:0] pool;

  // x & -x isolates the lowest set bit of the chosen pool
  always_comb begin
    upper = req & ~((N'(1) << ptr) - N'(1));
    pool  = (|upper) ? upper : req;
    pick  = pool & (~pool + N'(1));
  end

endmodule

// File: rtl/dsp_adder_arbiter.sv
// Shares one registered DSP post-adder between NREQ requesters with per-cycle
// round-robin arbitration and lockable bursts bounded by MAX_BURST cycles.
module dsp_adder_arbiter
  import dsp_adder_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                reset,
  dsp_adder_arbiter_if.slave  req_bus,
  dsp_adder_bus_if.master     adder_bus,
  output logic                lock_err
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST);

  if (NREQ < 2 || NREQ > ARB_MAX_NREQ || MAX_BURST < 2) begin : g_bad_param
    $error("dsp_adder_arbiter: NREQ must be 2..8 and MAX_BURST >= 2");
  end

  arb_state_e      state_q;
  arb_state_e      state_d;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   owner_d;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   rr_ptr_d;
  logic [BW-1:0]   burst_q;
  logic [BW-1:0]   burst_d;
  logic            lock_err_d;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_lock;
  logic            forced;

  rr_pick #(.N(NREQ)) u_rr_pick (
    .req  (req_bus.req),
    .ptr  (rr_ptr_q),
    .pick (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      burst_q       <= '0;
      lock_err      <= 1'b0;
      req_bus.p_vld <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_q       <= burst_d;
      lock_err      <= lock_err_d;
      req_bus.p_vld <= gnt;
    end
  end

  // The last cycle a lock may own the adder; its grant is still issued.
  assign forced   = (state_q == ARB_OWNED) && (burst_q == BW'(MAX_BURST - 1));
  assign gnt_lock = |(gnt & req_bus.lock);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    burst_d    = burst_q;
    lock_err_d = lock_err;
    gnt_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
    case (state_q)
      ARB_IDLE: begin
        if (|gnt) begin
          if (gnt_lock) begin
            state_d = ARB_OWNED;
            owner_d = gnt_idx;
            burst_d = BW'(1);
          end else begin
            rr_ptr_d = PW'(wrap_inc(int'(gnt_idx), NREQ));
          end
        end
      end
      ARB_OWNED: begin
        burst_d = burst_q + BW'(1);
        if (forced || ((|gnt) && !gnt_lock)) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = PW'(wrap_inc(int'(owner_q), NREQ));
          burst_d  = '0;
        end
        if (forced) lock_err_d = 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant is held off during reset so the adder sees a NOP immediately.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      case (state_q)
        ARB_IDLE:  gnt = pick;
        ARB_OWNED: gnt = req_bus.req & (NREQ'(1) << owner_q);
        default:   gnt = '0;
      endcase
    end
  end

  always_comb begin
    adder_bus.opmode = DSP_NOP;
    adder_bus.dab    = '0;
    adder_bus.c      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        adder_bus.opmode = req_bus.opmode_in[8*i +: 8];
        adder_bus.dab    = req_bus.dab_in[48*i +: 48];
        adder_bus.c      = req_bus.c_in[48*i +: 48];
      end
    end
  end

  assign req_bus.gnt   = gnt;
  assign req_bus.p_out = adder_bus.p_in;

endmodule

// File: tb/tb_dsp_adder_arbiter.sv
// Bench for dsp_adder_arbiter: fixed vector table, hand-written burst/reset
// sequences and random traffic against a cycle-level arbitration model.
module tb_dsp_adder_arbiter;
  import dsp_adder_arbiter_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] lock;
    logic [NREQ-1:0] gnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic lock_err;

  always #5 clk = ~clk;

  dsp_adder_arbiter_if #(.NREQ(NREQ)) req_bus ();
  dsp_adder_bus_if                    adder_bus ();

  dsp_adder_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_bus   (req_bus),
    .adder_bus (adder_bus),
    .lock_err  (lock_err)
  );

  logic [7:0]  op_arr  [NREQ];
  logic [47:0] dab_arr [NREQ];
  logic [47:0] c_arr   [NREQ];

  always_comb begin
    req_bus.opmode_in = '0;
    req_bus.dab_in    = '0;
    req_bus.c_in      = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_bus.opmode_in[8*i +: 8] = op_arr[i];
      req_bus.dab_in[48*i +: 48]  = dab_arr[i];
      req_bus.c_in[48*i +: 48]    = c_arr[i];
    end
  end

  // Behavioural stand-in for the registered post-adder
  logic [47:0] p_reg;
  logic [47:0] x_sel;
  logic [47:0] z_sel;

  always_comb begin
    x_sel = (adder_bus.opmode[1:0] == 2'b11) ? adder_bus.dab : 48'h0;
    case (adder_bus.opmode[3:2])
      2'b11:   z_sel = adder_bus.c;
      2'b10:   z_sel = p_reg;
      default: z_sel = 48'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_reg <= '0;
    else       p_reg <= x_sel + z_sel;
  end

  assign adder_bus.p_in = p_reg;

  int checks = 0;
  int errors = 0;

  int              m_owner;
  int              m_ptr;
  int              m_cycles;
  bit              m_err;
  logic [NREQ-1:0] m_prev_gnt;
  logic [47:0]     m_p;
  bit              m_p_known;

  vec_t vecs [16];

  task automatic check_val(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int one_hot_idx(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) return i;
    end
    return -1;
  endfunction

  // Owner takes the adder exclusively; otherwise scan from the pointer, wrapping
  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] g;
    int j;
    g = '0;
    if (m_owner >= 0) begin
      if (r[m_owner]) g[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (r[j] && g == '0) g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_cycles   = 0;
    m_err      = 1'b0;
    m_prev_gnt = '0;
    m_p        = '0;
    m_p_known  = 1'b0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    logic [NREQ-1:0] g;
    int j;
    bit forced_rel;
    g = model_gnt(r);
    j = one_hot_idx(g);
    if (j >= 0) begin
      if (op_arr[j] == DSP_ADD_C) begin
        m_p       = dab_arr[j] + c_arr[j];
        m_p_known = 1'b1;
      end else if (op_arr[j] == DSP_ADD_POUT) begin
        m_p = dab_arr[j] + m_p;
      end else begin
        m_p_known = 1'b0;
      end
    end else begin
      m_p_known = 1'b0;
    end
    if (m_owner < 0) begin
      if (j >= 0) begin
        if (l[j]) begin
          m_owner  = j;
          m_cycles = 1;
        end else begin
          m_ptr = (j + 1) % NREQ;
        end
      end
    end else begin
      m_cycles++;
      forced_rel = (m_cycles >= MAX_BURST);
      if (forced_rel || (j >= 0 && !l[j])) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
      if (forced_rel) m_err = 1'b1;
    end
    m_prev_gnt = g;
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    req_bus.req  = r;
    req_bus.lock = l;
  endtask

  task automatic check_output(input logic [NREQ-1:0] exp_gnt, input string name);
    int j;
    logic [7:0]  exp_op;
    logic [47:0] exp_dab;
    logic [47:0] exp_c;
    j       = one_hot_idx(exp_gnt);
    exp_op  = (j < 0) ? DSP_NOP : op_arr[j];
    exp_dab = (j < 0) ? 48'h0 : dab_arr[j];
    exp_c   = (j < 0) ? 48'h0 : c_arr[j];
    check_val({name, "_gnt"}, 48'(req_bus.gnt), 48'(exp_gnt));
    check_val({name, "_p_vld"}, 48'(req_bus.p_vld), 48'(m_prev_gnt));
    check_val({name, "_lock_err"}, 48'(lock_err), 48'(m_err));
    check_val({name, "_opmode"}, 48'(adder_bus.opmode), 48'(exp_op));
    check_val({name, "_dab"}, adder_bus.dab, exp_dab);
    check_val({name, "_c"}, adder_bus.c, exp_c);
    if (m_prev_gnt != '0 && m_p_known) check_val({name, "_p_out"}, req_bus.p_out, m_p);
  endtask

  task automatic run_cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                           input logic [NREQ-1:0] exp_gnt, input string name);
    apply_stimulus(r, l);
    @(negedge clk);
    check_output(exp_gnt, name);
    @(posedge clk);
    model_step(r, l);
    #1;
  endtask

  task automatic set_default_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i]  = DSP_ADD_C;
      dab_arr[i] = 48'h1000 * 48'(i + 1);
      c_arr[i]   = 48'h10 * 48'(i + 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus('0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0010};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0100};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b1000};
    vecs[8]  = '{4'b1010, 4'b0000, 4'b0010};
    vecs[9]  = '{4'b1010, 4'b0000, 4'b1000};
    vecs[10] = '{4'b0100, 4'b0000, 4'b0100};
    vecs[11] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[13] = '{4'b0101, 4'b0000, 4'b0100};
    vecs[14] = '{4'b0101, 4'b0000, 4'b0001};
    vecs[15] = '{4'b1001, 4'b0000, 4'b1000};

    set_default_ops();
    model_reset();
    reset = 1'b1;
    apply_stimulus('0, '0);
    #1;
    check_val("reset_gnt", 48'(req_bus.gnt), 48'h0);
    check_val("reset_p_vld", 48'(req_bus.p_vld), 48'h0);
    check_val("reset_lock_err", 48'(lock_err), 48'h0);
    check_val("reset_opmode", 48'(adder_bus.opmode), 48'(DSP_NOP));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 10; n++) run_cycle(4'b0000, 4'b0000, 4'b0000, "idle");

    for (int v = 0; v < 16; v++) run_cycle(vecs[v].req, vecs[v].lock, vecs[v].gnt, "table");

    // Locked accumulation chain on requester 0 while requester 2 waits
    do_reset();
    op_arr[0]  = DSP_ADD_C;
    dab_arr[0] = 48'h20000;
    c_arr[0]   = 48'h0;
    run_cycle(4'b0101, 4'b0001, 4'b0001, "chain0");
    check_val("chain_p1", req_bus.p_out, 48'h20000);
    op_arr[0] = DSP_ADD_POUT;
    run_cycle(4'b0101, 4'b0001, 4'b0001, "chain1");
    check_val("chain_p2", req_bus.p_out, 48'h40000);
    run_cycle(4'b0101, 4'b0001, 4'b0001, "chain2");
    check_val("chain_p3", req_bus.p_out, 48'h60000);
    run_cycle(4'b0101, 4'b0000, 4'b0001, "chain3");
    check_val("chain_p4", req_bus.p_out, 48'h80000);
    run_cycle(4'b0101, 4'b0000, 4'b0100, "chain_next");

    // Owner 1 drops its request mid-lock; requester 3 must not sneak in
    do_reset();
    set_default_ops();
    run_cycle(4'b1010, 4'b0010, 4'b0010, "drop_acq");
    run_cycle(4'b1010, 4'b0010, 4'b0010, "drop_own");
    run_cycle(4'b1000, 4'b0010, 4'b0000, "drop_gap0");
    run_cycle(4'b1000, 4'b0010, 4'b0000, "drop_gap1");
    run_cycle(4'b1010, 4'b0000, 4'b0010, "drop_resume");
    run_cycle(4'b1000, 4'b0000, 4'b1000, "drop_next");

    // Lock held forever: ownership capped at MAX_BURST grants
    do_reset();
    for (int n = 0; n < MAX_BURST; n++) run_cycle(4'b0011, 4'b0001, 4'b0001, "forced_own");
    check_val("forced_err", 48'(lock_err), 48'h1);
    run_cycle(4'b0011, 4'b0001, 4'b0010, "forced_next");

    // Reset asserted while the owner is being granted
    do_reset();
    run_cycle(4'b0001, 4'b0001, 4'b0001, "rst_acq");
    run_cycle(4'b0001, 4'b0001, 4'b0001, "rst_own");
    apply_stimulus(4'b0001, 4'b0001);
    #1;
    check_val("rst_pre_gnt", 48'(req_bus.gnt), 48'h1);
    check_val("rst_pre_p_vld", 48'(req_bus.p_vld), 48'h1);
    reset = 1'b1;
    #1;
    check_val("rst_gnt", 48'(req_bus.gnt), 48'h0);
    check_val("rst_p_vld", 48'(req_bus.p_vld), 48'h0);
    check_val("rst_opmode", 48'(adder_bus.opmode), 48'(DSP_NOP));
    check_val("rst_dab", adder_bus.dab, 48'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run_cycle(4'b1111, 4'b0000, 4'b0001, "rst_first");

    // Random traffic with operands changing every cycle
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [NREQ-1:0] r;
      logic [NREQ-1:0] l;
      for (int i = 0; i < NREQ; i++) begin
        op_arr[i]  = ($urandom_range(0, 3) == 0) ? DSP_ADD_POUT : DSP_ADD_C;
        dab_arr[i] = 48'({$urandom(), $urandom()});
        c_arr[i]   = 48'({$urandom(), $urandom()});
      end
      r = NREQ'($urandom());
      l = ($urandom_range(0, 3) != 0) ? NREQ'($urandom()) | NREQ'(r) : NREQ'(0);
      run_cycle(r, l, model_gnt(r), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
